// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// No logic: constants, the FSM state type and the buffered-entry layout.
// Entries carry the instruction word together with the PC it was fetched from.
package fetch_pkg;

    // Address/data width the entry layout is built for; the top's N must match.
    localparam int FETCH_W = 32;

    // Word-sized PC step and the mask that clears the byte offset of a target.
    localparam logic [FETCH_W-1:0] PC_INC    = 32'd4;
    localparam logic [FETCH_W-1:0] WORD_MASK = ~(PC_INC - 32'd1);

    // Skid buffer holds two fetched words.
    localparam logic [1:0] FIFO_DEPTH = 2'd2;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        WAIT_BUF = 2'd1,
        DRAIN    = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_W-1:0] instr;
        logic [FETCH_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid buffer for fetched {instr, pc} pairs; head is always visible.
// Latency: a push is visible at the head on the next cycle when the buffer was empty.
// Backpressure: count reports occupancy; pop before push lets both happen at full.
module fetch_skid_fifo
    import fetch_pkg::*;
(
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         clear,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t mem_q [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_pop;
    logic         do_push;

    // A pop of an empty buffer is ignored; a push at full is legal only with a pop.
    assign do_pop  = pop & (count != 2'd0);
    assign do_push = push & ((count != FIFO_DEPTH) | do_pop);

    // Storage, pointers and occupancy; clear drops everything buffered.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr] <= push_entry;
                wr_ptr        <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head = mem_q[rd_ptr];

    // The fetch FSM never pushes into a full buffer unless the head leaves that cycle.
    a_no_overflow: assert property (@(posedge Clk) disable iff (!Rst_n)
        !(push && !pop && !clear && count == FIFO_DEPTH));

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns the PC, issues imem word requests and redirects on taken branches.
// Latency: ack at cycle t presents the instruction at t+1; 1 instr/cycle with zero-wait memory.
// Backpressure: Stall holds the head; with 2 words buffered requests stop (FETCH_MISALIGN_TRAP_EN adds a misaligned-target trap).
module fetch_pc_unit
    import fetch_pkg::*;
#(
    // Must equal FETCH_W: the buffered entry layout is fixed at that width.
    parameter int             N        = FETCH_W,
    parameter logic [N-1:0]   RESET_PC = '0
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         ExValid,
    input  logic         Taken,
    input  logic [N-1:0] TargetAddr,
    input  logic         Stall,
    output logic         ImemReq,
    output logic [N-1:0] ImemAddr,
    input  logic         ImemAck,
    input  logic [N-1:0] ImemRdata,
    output logic         InstrValid,
    output logic [N-1:0] Instr,
    output logic [N-1:0] InstrPc,
    output logic         Flush
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic         MisalignErr
`endif
);

    fetch_state_t state;
    logic [N-1:0] pc;
    logic [N-1:0] drain_addr;
    logic [N-1:0] target;
    logic         redirect;
    logic         ack;
    logic         push;
    logic         pop;
    logic [1:0]   count;
    logic [1:0]   cnt_after;
    logic         misalign_hit;
    logic         trapped;
    fetch_entry_t head;

    assign redirect = ExValid & Taken;
    assign Flush    = redirect;

    // Requests are dropped while in reset so memory never sees a stale request.
    assign ImemReq  = Rst_n & (state != WAIT_BUF);
    assign ImemAddr = (state == DRAIN) ? drain_addr : pc;

    // An ack without a live request is not ours.
    assign ack = ImemAck & ImemReq;

    // Only words fetched on the current path are buffered.
    assign push      = (state == FETCH) & ack & ~redirect;
    assign pop       = InstrValid & ~Stall;
    assign cnt_after = count + {1'b0, push} - {1'b0, pop};

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target       = TargetAddr;
    assign misalign_hit = redirect & (TargetAddr[1:0] != 2'b00);
    assign MisalignErr  = trapped;

    // Sticky misaligned-target flag; once set the unit parks with no requests.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            trapped <= 1'b0;
        end else if (misalign_hit) begin
            trapped <= 1'b1;
        end
    end
`else
    // Byte offset of a redirect target is dropped; fetch is always word aligned.
    assign target       = TargetAddr & WORD_MASK;
    assign misalign_hit = 1'b0;
    assign trapped      = 1'b0;
`endif

    // PC, drain address and fetch state; a redirect overrides stall, ack and buffer state.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
        end else if (trapped) begin
            state <= WAIT_BUF;
        end else if (redirect) begin
            pc <= target;
            // A request left unacked at redirect must finish at its original address.
            if (state == FETCH) begin
                drain_addr <= pc;
            end
            if (misalign_hit) begin
                state <= WAIT_BUF;
            end else if (state == WAIT_BUF) begin
                state <= FETCH;
            end else begin
                state <= ack ? FETCH : DRAIN;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (ack) begin
                        pc <= pc + PC_INC;
                        if (cnt_after == FIFO_DEPTH) begin
                            state <= WAIT_BUF;
                        end
                    end
                end
                WAIT_BUF: begin
                    if (pop) begin
                        state <= FETCH;
                    end
                end
                DRAIN: begin
                    // Response of the squashed path completes here and is discarded.
                    if (ack) begin
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    fetch_skid_fifo u_fifo (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .push       (push),
        .push_entry ('{instr: ImemRdata, pc: pc}),
        .pop        (pop),
        .clear      (redirect),
        .count      (count),
        .head       (head)
    );

    assign InstrValid = (count != 2'd0);
    assign Instr      = head.instr;
    assign InstrPc    = head.pc;

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch stage that owns the program counter and feeds the decode/execute pipeline that ends in the branch comparator. It issues word requests to instruction memory over a req/ack handshake, buffers returned instructions in a 2-entry skid FIFO, and redirects the PC when the execute stage reports a taken branch or jump. It discards any in-flight response belonging to the squashed path.

## Interface
- N, 32: address/data width.
- RESET_PC, 32'h0000_0000: PC value after reset.
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  synchronous reset, active-low.
- ExValid  in  1  execute-stage instruction valid.
- Taken  in  1  branch/jump taken from branch comparator; meaningful only with ExValid.
- TargetAddr  in  N  redirect target, valid with ExValid & Taken.
- Stall  in  1  decode cannot accept the presented instruction.
- ImemReq  out  1  fetch request.
- ImemAddr  out  N  fetch address.
- ImemAck  in  1  response valid, completes the request in the same cycle.
- ImemRdata  in  N  instruction word, valid with ImemAck.
- InstrValid  out  1  Instr/InstrPc valid.
- Instr  out  N  instruction to decode.
- InstrPc  out  N  PC of Instr.
- Flush  out  1  squash younger pipeline stages.
- MisalignErr  out  1  only with FETCH_MISALIGN_TRAP_EN.

## Operation
- Redirect = ExValid & Taken. Flush = Redirect, combinational. Redirect has priority over Stall, ack and FIFO state.
- States: FETCH, WAIT_BUF, DRAIN.
- ImemReq = 1 in FETCH and DRAIN; 0 in WAIT_BUF. ImemAddr = PC in FETCH; the old request address is held in DRAIN.
- FETCH, ack, no redirect:
  - push {ImemRdata, PC}; PC <= PC+4.
  - Go to WAIT_BUF if the FIFO count after push/pop = 2, else stay in FETCH.
- FETCH, redirect:
  - FIFO cleared; PC <= TargetAddr.
  - Same-cycle ack is discarded.
  - Next state = FETCH if ack this cycle, else DRAIN.
- DRAIN:
  - Request held at the old address until ack; the ack data is discarded, then go to FETCH.
  - A redirect in DRAIN updates PC to the newest target and stays in DRAIN (or goes to FETCH if ack arrives the same cycle).
- WAIT_BUF:
  - Pop (InstrValid & !Stall) makes count < 2; go to FETCH.
  - Redirect clears the FIFO; PC <= TargetAddr; go to FETCH.
- FIFO:
  - Head drives Instr/InstrPc; InstrValid = count != 0.
  - Push and pop in the same cycle is allowed, including at count 2 (pop first).
  - Push while count = 2 without pop cannot occur by construction; verification asserts this.
- PC arithmetic is modulo 2^N; wraparound from 32'hFFFF_FFFC to 0 is legal.
- Handshake: once ImemReq rises, ImemAddr is stable and ImemReq stays high until the ack cycle. Ack with ImemReq low is ignored.

## Timing
- Reset (Rst_n low at an edge): PC = RESET_PC, state = FETCH, FIFO empty.
  - Outputs during/after reset: InstrValid = 0, Instr = 0, InstrPc = 0, MisalignErr = 0.
  - Flush is combinational and follows its inputs.
  - Outstanding requests are abandoned; imem resets with the same Rst_n.
- First ImemReq is high in the first cycle after reset deasserts.
- Ack at cycle t gives InstrValid at t+1.
- Zero-wait memory sustains 1 instruction/cycle with Stall low.
- Redirect at cycle t: InstrValid = 0 at t+1. The first request to TargetAddr issues at t+1 (ack at t) or the cycle after the DRAIN ack.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A redirect with TargetAddr[1:0] != 0 sets MisalignErr (sticky until reset) and stores the target in PC.
  - The unit then stops issuing requests: next state WAIT_BUF, held there, with the FIFO cleared.
- Undefined:
  - TargetAddr[1:0] is forced to 0 on redirect.
  - The MisalignErr port is absent.

## Structure
- Shared package fetch_pkg:
  - state enum {FETCH, WAIT_BUF, DRAIN};
  - PC_INC = 4;
  - FIFO_DEPTH = 2;
  - the {instr, pc} entry struct.
- Sub-module fetch_skid_fifo: 2-entry synchronous FIFO with push, pop, clear, count, and head outputs, reset by Rst_n.

## Test plan
- Reset release, zero-wait ack, Stall low:
  - ImemAddr issues 0, 4, 8, 12 on consecutive cycles.
  - InstrPc follows one cycle later, InstrValid continuous.
- Stall high for 5 cycles from the first valid instruction:
  - FIFO fills to 2 and ImemReq drops.
  - On release, instructions at 0, 4, 8 are delivered in order, with no duplicates or losses.
- Ack delayed 3 cycles, redirect to 0x100 in the second wait cycle:
  - ImemAddr stays at the old address until the ack, whose data is never presented.
  - The next request is 0x100.
- Redirect to 0x200 in the same cycle as an ack for 0x10:
  - Flush = 1, the 0x10 word is discarded.
  - Next ImemAddr = 0x200; InstrValid = 0 for one cycle.
- Redirect while in WAIT_BUF with 2 buffered entries: FIFO emptied, next InstrPc = target.
- Redirect to 0x102:
  - With the macro: MisalignErr = 1, no further ImemReq.
  - Without the macro: fetch proceeds at 0x100.
